// File: rtl/fifo_to_mem_mq_if.sv
// rtl/fifo_to_mem_mq_if.sv - FIFO pop and memory write bus bundle for fifo_to_mem_mq
// Purpose: groups the packet FIFO read side and the burst memory write side.
// Signals:
//   fifo_rd_en (pop), fifo_data, fifo_qid, fifo_eop, fifo_empty
//   mem_ad_w_n / mem_d_w_n (active-low strobes), mem_wr_full (backpressure),
//   mem_ad_wr (burst address), mem_bwl_n / mem_bwh_n (byte-write strobes),
//   mem_dwl / mem_dwh (low / high data halves)
// Modports: master = writer block, slave = FIFO + memory side.
interface fifo_to_mem_mq_if #(
  parameter int NUM_QUEUES_BITS = 2,
  parameter int FIFO_DATA_WIDTH = 144,
  parameter int MEM_ADDR_WIDTH  = 19,
  parameter int MEM_DATA_WIDTH  = FIFO_DATA_WIDTH / 2,
  parameter int MEM_BW_WIDTH    = 4
);
  logic                       fifo_rd_en;
  logic [FIFO_DATA_WIDTH-1:0] fifo_data;
  logic [NUM_QUEUES_BITS-1:0] fifo_qid;
  logic                       fifo_eop;
  logic                       fifo_empty;
  logic                       mem_ad_w_n;
  logic                       mem_d_w_n;
  logic                       mem_wr_full;
  logic [MEM_ADDR_WIDTH-1:0]  mem_ad_wr;
  logic [MEM_BW_WIDTH-1:0]    mem_bwl_n;
  logic [MEM_BW_WIDTH-1:0]    mem_bwh_n;
  logic [MEM_DATA_WIDTH-1:0]  mem_dwl;
  logic [MEM_DATA_WIDTH-1:0]  mem_dwh;

  modport master (
    output fifo_rd_en,
    input  fifo_data, fifo_qid, fifo_eop, fifo_empty,
    output mem_ad_w_n, mem_d_w_n, mem_ad_wr, mem_bwl_n, mem_bwh_n, mem_dwl, mem_dwh,
    input  mem_wr_full
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_data, fifo_qid, fifo_eop, fifo_empty,
    input  mem_ad_w_n, mem_d_w_n, mem_ad_wr, mem_bwl_n, mem_bwh_n, mem_dwl, mem_dwh,
    output mem_wr_full
  );
endinterface

// File: rtl/fifo_to_mem_mq.sv
// rtl/fifo_to_mem_mq.sv - multi-queue packet FIFO to burst-of-4 memory writer
// Purpose: pops packet words tagged with a queue id and writes them into that
// queue's memory region; two consecutive words share one address strobe, and
// odd-length packets get a masked pad beat so every packet ends on a burst.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   bus                   FIFO pop side + memory write side (master modport)
//   q_addr_low/q_addr_high per-queue burst-address region [low,high)
//   q_enable, q_wrap      per-queue enable and ring mode
//   sw_enable             0 idles the block and reloads pointers/counters
//   cal_done              memory calibrated; 0 stalls
//   q_commit_ptr          per-queue word pointer after last committed packet
//   q_pkt_cnt, q_drop_cnt per-queue saturating packet / overflow-drop counts
module fifo_to_mem_mq #(
  parameter int NUM_QUEUES      = 4,
  parameter int NUM_QUEUES_BITS = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
  parameter int FIFO_DATA_WIDTH = 144,
  parameter int MEM_ADDR_WIDTH  = 19,
  parameter int MEM_DATA_WIDTH  = FIFO_DATA_WIDTH / 2,
  parameter int MEM_BW_WIDTH    = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  fifo_to_mem_mq_if.master                        bus,
  input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0]    q_addr_low,
  input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0]    q_addr_high,
  input  logic [NUM_QUEUES-1:0]                   q_enable,
  input  logic [NUM_QUEUES-1:0]                   q_wrap,
  input  logic                                    sw_enable,
  input  logic                                    cal_done,
  output logic [NUM_QUEUES*(MEM_ADDR_WIDTH+1)-1:0] q_commit_ptr,
  output logic [NUM_QUEUES*32-1:0]                q_pkt_cnt,
  output logic [NUM_QUEUES*32-1:0]                q_drop_cnt
);
  localparam int PW = MEM_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, PKT, PAD, DROP} state_t;

  state_t                     state_q;
  logic [NUM_QUEUES_BITS-1:0] lock_q;
  logic [PW-1:0]              wp_q       [NUM_QUEUES];
  logic [PW-1:0]              cp_q       [NUM_QUEUES];
  logic [31:0]                pkt_cnt_q  [NUM_QUEUES];
  logic [31:0]                drop_cnt_q [NUM_QUEUES];

  logic [NUM_QUEUES_BITS-1:0] qid, qsel;
  logic                       qid_ok, q_on, go, at_end;
  logic                       wr_word, discard, pad_go, drop_pop;
  logic [PW-1:0]              reg_low, reg_end, wp_cur, wp_wr, wp_inc;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // In IDLE the queue comes from the FIFO head; afterwards it is locked for
  // the rest of the packet. Out-of-range ids are treated as disabled queues.
  always_comb begin
    qid      = (state_q == IDLE) ? bus.fifo_qid : lock_q;
    qid_ok   = int'(qid) < NUM_QUEUES;
    qsel     = qid_ok ? qid : '0;
    reg_low  = {q_addr_low[int'(qsel)*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH], 1'b0};
    reg_end  = {q_addr_high[int'(qsel)*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH], 1'b0};
    wp_cur   = wp_q[qsel];
    at_end   = (wp_cur == reg_end);
    // Ring queues restart at the region base without losing the word.
    wp_wr    = at_end ? reg_low : wp_cur;
    wp_inc   = wp_wr + 1'b1;
    q_on     = qid_ok && q_enable[qsel];
    go       = rst_n && sw_enable && cal_done && !bus.fifo_empty && !bus.mem_wr_full;
    wr_word  = go && ((state_q == PKT) || ((state_q == IDLE) && q_on));
    discard  = wr_word && at_end && !q_wrap[qsel];
    pad_go   = rst_n && sw_enable && cal_done && !bus.mem_wr_full && (state_q == PAD);
    // Dropping ignores memory backpressure since nothing is written.
    drop_pop = rst_n && sw_enable && cal_done && !bus.fifo_empty && (state_q == DROP);
    bus.fifo_rd_en = wr_word || drop_pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      lock_q         <= '0;
      bus.mem_ad_w_n <= 1'b1;
      bus.mem_d_w_n  <= 1'b1;
      bus.mem_ad_wr  <= '0;
      bus.mem_bwl_n  <= '0;
      bus.mem_bwh_n  <= '0;
      bus.mem_dwl    <= '0;
      bus.mem_dwh    <= '0;
      for (int i = 0; i < NUM_QUEUES; i++) begin
        wp_q[i]       <= '0;
        cp_q[i]       <= '0;
        pkt_cnt_q[i]  <= '0;
        drop_cnt_q[i] <= '0;
      end
    end else if (!sw_enable) begin
      state_q        <= IDLE;
      bus.mem_ad_w_n <= 1'b1;
      bus.mem_d_w_n  <= 1'b1;
      for (int i = 0; i < NUM_QUEUES; i++) begin
        wp_q[i]       <= {q_addr_low[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH], 1'b0};
        cp_q[i]       <= {q_addr_low[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH], 1'b0};
        pkt_cnt_q[i]  <= '0;
        drop_cnt_q[i] <= '0;
      end
    end else begin
      bus.mem_ad_w_n <= 1'b1;
      bus.mem_d_w_n  <= 1'b1;

      if ((state_q == IDLE) && go) begin
        lock_q <= qsel;
        // Disabled queue: leave the word in the FIFO; DROP consumes it.
        if (!q_on) state_q <= DROP;
      end

      if (wr_word) begin
        if (discard) begin
          // Region full: abandon the partial packet back to the last commit.
          wp_q[qsel]       <= cp_q[qsel];
          drop_cnt_q[qsel] <= sat_inc(drop_cnt_q[qsel]);
          state_q          <= bus.fifo_eop ? IDLE : DROP;
        end else begin
          bus.mem_ad_w_n <= wp_wr[0];
          bus.mem_d_w_n  <= 1'b0;
          if (!wp_wr[0]) bus.mem_ad_wr <= wp_wr[PW-1:1];
          bus.mem_dwl    <= bus.fifo_data[MEM_DATA_WIDTH-1:0];
          bus.mem_dwh    <= bus.fifo_data[MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
          bus.mem_bwl_n  <= '0;
          bus.mem_bwh_n  <= '0;
          wp_q[qsel]     <= wp_inc;
          if (!bus.fifo_eop) begin
            state_q <= PKT;
          end else if (wp_inc[0]) begin
            state_q <= PAD;
          end else begin
            cp_q[qsel]      <= wp_inc;
            pkt_cnt_q[qsel] <= sat_inc(pkt_cnt_q[qsel]);
            state_q         <= IDLE;
          end
        end
      end

      // Pad beat completes the burst; its pointer is odd so it never hits the
      // (even) region end.
      if (pad_go) begin
        bus.mem_d_w_n   <= 1'b0;
        bus.mem_dwl     <= '0;
        bus.mem_dwh     <= '0;
        bus.mem_bwl_n   <= '1;
        bus.mem_bwh_n   <= '1;
        wp_q[qsel]      <= wp_cur + 1'b1;
        cp_q[qsel]      <= wp_cur + 1'b1;
        pkt_cnt_q[qsel] <= sat_inc(pkt_cnt_q[qsel]);
        state_q         <= IDLE;
      end

      if (drop_pop && bus.fifo_eop) state_q <= IDLE;
    end
  end

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_status
    assign q_commit_ptr[g*PW +: PW] = cp_q[g];
    assign q_pkt_cnt[g*32 +: 32]    = pkt_cnt_q[g];
    assign q_drop_cnt[g*32 +: 32]   = drop_cnt_q[g];
  end
endmodule
